// File: rtl/qos_channel_selector.sv
// -----------------------------------------------------------------------------
// qos_channel_selector
//
// Picks one of four transport-stream input channels according to a
// configurable priority list and per-channel health. It fails over
// automatically when the active channel degrades, and it locks out further
// automatic switches for a hold-off period after every automatic switch.
// Manual override forces a specific channel. A free-running error window
// strobes a clear to every channel's error counter.
//
// Parameters
//   ERR_THRESH      error count at or above which a channel is unhealthy
//   HOLDOFF_CYCLES  post-switch lockout length in clk cycles (>= 1)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   fallback_enable               allow automatic failover / revert
//   manual_enable, manual_channel manual override and its channel
//   channel_priority              rank list, [1:0] highest .. [7:6] lowest
//   reset_timer                   error window length, 0 disables
//   valid_config                  register block configuration is valid
//   signal_present                per-channel carrier detect
//   error_count_ch0..ch3          per-channel error counters
//   active_channel                selected channel
//   channel_valid                 selected channel is healthy
//   switch_pulse                  one-cycle strobe on any active_channel change
//   holdoff_active                lockout in progress
//   error_clear                   per-channel error counter clear strobe
//   no_signal                     no healthy channel available
//
// Every output is registered, so each one responds one cycle after its inputs.
// -----------------------------------------------------------------------------
module qos_channel_selector #(
  parameter logic [7:0]  ERR_THRESH     = 8'd16,
  parameter int unsigned HOLDOFF_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fallback_enable,
  input  logic        manual_enable,
  input  logic [1:0]  manual_channel,
  input  logic [7:0]  channel_priority,
  input  logic [19:0] reset_timer,
  input  logic        valid_config,
  input  logic [3:0]  signal_present,
  input  logic [7:0]  error_count_ch0,
  input  logic [7:0]  error_count_ch1,
  input  logic [7:0]  error_count_ch2,
  input  logic [7:0]  error_count_ch3,
  output logic [1:0]  active_channel,
  output logic        channel_valid,
  output logic        switch_pulse,
  output logic        holdoff_active,
  output logic [3:0]  error_clear,
  output logic        no_signal
);

  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CYCLES - 1);

  localparam logic [2:0] StWaitCfg = 3'd0;
  localparam logic [2:0] StManual  = 3'd1;
  localparam logic [2:0] StAutoRun = 3'd2;
  localparam logic [2:0] StHoldoff = 3'd3;
  localparam logic [2:0] StNoSig   = 3'd4;

  // ---------------------------------------------------------------------------
  // Channel health and best-channel selection
  // ---------------------------------------------------------------------------
  logic [7:0] err_cnt [4];
  logic [3:0] healthy;
  logic [1:0] best;
  logic       best_valid;

  assign err_cnt[0] = error_count_ch0;
  assign err_cnt[1] = error_count_ch1;
  assign err_cnt[2] = error_count_ch2;
  assign err_cnt[3] = error_count_ch3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      healthy[i] = signal_present[i] && (err_cnt[i] < ERR_THRESH);
    end
  end

  // Scan from lowest rank up so the highest-ranked healthy entry wins. Duplicate
  // entries resolve to the same channel, and unlisted channels never appear.
  always_comb begin
    best       = 2'd0;
    best_valid = 1'b0;
    for (int r = 3; r >= 0; r--) begin
      if (healthy[channel_priority[2*r +: 2]]) begin
        best       = channel_priority[2*r +: 2];
        best_valid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selection FSM
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [1:0]       active_q, active_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    hold_cnt_d = hold_cnt_q;

    if (!valid_config) begin
      state_d  = StWaitCfg;
      active_d = 2'd0;
    end else if ((state_q != StWaitCfg) && manual_enable) begin
      // Manual override wins over every running state, including hold-off.
      state_d  = StManual;
      active_d = manual_channel;
    end else begin
      case (state_q)
        StWaitCfg: begin
          if (manual_enable) begin
            state_d  = StManual;
            active_d = manual_channel;
          end else if (best_valid) begin
            state_d  = StAutoRun;
            active_d = best;
          end else begin
            state_d  = StNoSig;
            active_d = channel_priority[1:0];
          end
        end

        StManual: begin
          // manual_enable is low here; keep the last manual channel.
          state_d = StAutoRun;
        end

        StAutoRun: begin
          if (healthy == 4'b0000) begin
            state_d = StNoSig;
          end else if (fallback_enable && best_valid && (best != active_q)) begin
            state_d    = StHoldoff;
            active_d   = best;
            hold_cnt_d = '0;
          end
        end

        StHoldoff: begin
          if (hold_cnt_q == HoldLast) begin
            state_d = StAutoRun;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end

        StNoSig: begin
          if (fallback_enable) begin
            if (best_valid) begin
              state_d    = StHoldoff;
              active_d   = best;
              hold_cnt_d = '0;
            end
          end else if (healthy[active_q]) begin
            state_d = StAutoRun;
          end
        end

        default: begin
          state_d  = StWaitCfg;
          active_d = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error window counter
  // ---------------------------------------------------------------------------
  logic [19:0] win_q, win_d;
  logic        win_fire;

  // Use >= rather than == so that lowering reset_timer below the current count
  // fires on the next cycle instead of wrapping the full 20-bit range.
  always_comb begin
    win_fire = (reset_timer != 20'd0) && (win_q >= (reset_timer - 20'd1));
    if (reset_timer == 20'd0) begin
      win_d = 20'd0;
    end else if (win_fire) begin
      win_d = 20'd0;
    end else begin
      win_d = win_q + 20'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic       switch_pulse_d;
  logic       channel_valid_d;
  logic       holdoff_active_d;
  logic       no_signal_d;
  logic [3:0] error_clear_d;

  logic       switch_pulse_q;
  logic       channel_valid_q;
  logic       holdoff_active_q;
  logic       no_signal_q;
  logic [3:0] error_clear_q;

  always_comb begin
    switch_pulse_d   = (active_d != active_q);
    channel_valid_d  = (state_d != StWaitCfg) && healthy[active_d];
    holdoff_active_d = (state_d == StHoldoff);
    no_signal_d      = (state_d == StNoSig);
    error_clear_d    = win_fire ? 4'b1111 : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StWaitCfg;
      active_q         <= 2'd0;
      hold_cnt_q       <= '0;
      win_q            <= 20'd0;
      switch_pulse_q   <= 1'b0;
      channel_valid_q  <= 1'b0;
      holdoff_active_q <= 1'b0;
      no_signal_q      <= 1'b0;
      error_clear_q    <= 4'b0000;
    end else begin
      state_q          <= state_d;
      active_q         <= active_d;
      hold_cnt_q       <= hold_cnt_d;
      win_q            <= win_d;
      switch_pulse_q   <= switch_pulse_d;
      channel_valid_q  <= channel_valid_d;
      holdoff_active_q <= holdoff_active_d;
      no_signal_q      <= no_signal_d;
      error_clear_q    <= error_clear_d;
    end
  end

  assign active_channel = active_q;
  assign channel_valid  = channel_valid_q;
  assign switch_pulse   = switch_pulse_q;
  assign holdoff_active = holdoff_active_q;
  assign no_signal      = no_signal_q;
  assign error_clear    = error_clear_q;

endmodule

// File: tb/tb_qos_channel_selector.sv
// -----------------------------------------------------------------------------
// tb_qos_channel_selector
//
// Directed scenarios for configuration, failover and hold-off, loss of signal,
// manual override, the error window and reset. These are followed by a long
// randomized run checked cycle by cycle against a behavioural model of the
// selection rules.
// -----------------------------------------------------------------------------
module tb_qos_channel_selector;

  localparam int H = 8;

  logic        clk;
  logic        rst;
  logic        fallback_enable;
  logic        manual_enable;
  logic [1:0]  manual_channel;
  logic [7:0]  channel_priority;
  logic [19:0] reset_timer;
  logic        valid_config;
  logic [3:0]  signal_present;
  logic [7:0]  err [4];
  logic [1:0]  active_channel;
  logic        channel_valid;
  logic        switch_pulse;
  logic        holdoff_active;
  logic [3:0]  error_clear;
  logic        no_signal;

  int n_tests = 0;
  int n_fail  = 0;

  qos_channel_selector #(
    .ERR_THRESH    (8'd16),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fallback_enable (fallback_enable),
    .manual_enable   (manual_enable),
    .manual_channel  (manual_channel),
    .channel_priority(channel_priority),
    .reset_timer     (reset_timer),
    .valid_config    (valid_config),
    .signal_present  (signal_present),
    .error_count_ch0 (err[0]),
    .error_count_ch1 (err[1]),
    .error_count_ch2 (err[2]),
    .error_count_ch3 (err[3]),
    .active_channel  (active_channel),
    .channel_valid   (channel_valid),
    .switch_pulse    (switch_pulse),
    .holdoff_active  (holdoff_active),
    .error_clear     (error_clear),
    .no_signal       (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int MWait = 0, MMan = 1, MAuto = 2, MHold = 3, MNone = 4;

  int         m_mode = MWait;
  int         m_act  = 0;
  int         m_left = 0;   // hold-off cycles still to run
  int         m_win  = 0;   // cycles since the last error clear
  logic [1:0] e_act;
  logic       e_valid, e_pulse, e_hold, e_nosig;
  logic [3:0] e_clr;

  function automatic logic [3:0] tb_healthy();
    logic [3:0] h;
    for (int i = 0; i < 4; i++) h[i] = signal_present[i] && (err[i] < 8'd16);
    return h;
  endfunction

  // Walk the rank list from the top; the first healthy entry wins. -1 = none.
  function automatic int find_best(input logic [3:0] h);
    for (int r = 0; r < 4; r++) begin
      int c;
      c = int'((channel_priority >> (2 * r)) & 8'h3);
      if (h[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    logic [3:0] h;
    int b;
    int prev;
    h    = tb_healthy();
    b    = find_best(h);
    prev = m_act;
    if (rst) begin
      m_mode = MWait; m_act = 0; m_left = 0; m_win = 0;
      e_clr = 4'h0; e_pulse = 0; e_hold = 0; e_nosig = 0; e_valid = 0;
    end else begin
      if (reset_timer == 0) begin
        m_win = 0; e_clr = 4'h0;
      end else if (m_win + 1 >= int'(reset_timer)) begin
        m_win = 0; e_clr = 4'hF;
      end else begin
        m_win++; e_clr = 4'h0;
      end
      if (!valid_config) begin
        m_mode = MWait; m_act = 0;
      end else if (m_mode != MWait && manual_enable) begin
        m_mode = MMan; m_act = int'(manual_channel);
      end else begin
        case (m_mode)
          MWait: begin
            if (manual_enable) begin
              m_mode = MMan; m_act = int'(manual_channel);
            end else if (b >= 0) begin
              m_mode = MAuto; m_act = b;
            end else begin
              m_mode = MNone; m_act = int'(channel_priority & 8'h3);
            end
          end
          MMan: m_mode = MAuto;
          MAuto: begin
            if (h == 4'b0) m_mode = MNone;
            else if (fallback_enable && b >= 0 && b != m_act) begin
              m_act = b; m_mode = MHold; m_left = H;
            end
          end
          MHold: begin
            m_left--;
            if (m_left == 0) m_mode = MAuto;
          end
          default: begin
            if (fallback_enable) begin
              if (b >= 0) begin m_act = b; m_mode = MHold; m_left = H; end
            end else if (h[m_act]) m_mode = MAuto;
          end
        endcase
      end
      e_pulse = (m_act != prev);
      e_hold  = (m_mode == MHold);
      e_nosig = (m_mode == MNone);
      e_valid = (m_mode != MWait) && h[m_act];
    end
    e_act = 2'(m_act);
    @(posedge clk);
    #1;
  endtask

  // Reset, then bring the configuration valid: channel 2 selected in AUTO_RUN.
  task automatic setup_config();
    rst = 1; valid_config = 0; manual_enable = 0; fallback_enable = 1;
    channel_priority = 8'b00_01_11_10; signal_present = 4'hF; reset_timer = 0;
    for (int i = 0; i < 4; i++) err[i] = 8'd0;
    step();
    rst = 0;
    step();
    valid_config = 1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1;
    step();
    n_tests++;
    if (active_channel !== 2'd0) begin
      n_fail++; $display("FAIL reset_active got %0d want 0", active_channel);
    end
    n_tests++;
    if ({channel_valid, switch_pulse, holdoff_active, no_signal, error_clear} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags got v%b p%b h%b n%b c%h want all 0", channel_valid,
               switch_pulse, holdoff_active, no_signal, error_clear);
    end
  endtask

  task automatic test_config();
    rst = 0; valid_config = 0;
    step();
    n_tests++;
    if ({active_channel, channel_valid} !== 3'b00_0) begin
      n_fail++;
      $display("FAIL wait_cfg got act=%0d v=%b want 0/0", active_channel, channel_valid);
    end
    valid_config = 1;
    step();
    n_tests++;
    if ({active_channel, switch_pulse, channel_valid, no_signal, holdoff_active}
        !== {2'd2, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL cfg_select got act=%0d p=%b v=%b n=%b h=%b want 2/1/1/0/0", active_channel,
               switch_pulse, channel_valid, no_signal, holdoff_active);
    end
    step();
    n_tests++;
    if ({active_channel, switch_pulse} !== {2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL cfg_steady got act=%0d p=%b want 2/0", active_channel, switch_pulse);
    end
  endtask

  task automatic test_failover();
    setup_config();
    err[2] = 8'd16;
    step();
    n_tests++;
    if ({active_channel, switch_pulse, holdoff_active, channel_valid} !== {2'd3, 3'b111}) begin
      n_fail++;
      $display("FAIL failover_switch got act=%0d p=%b h=%b v=%b want 3/1/1/1", active_channel,
               switch_pulse, holdoff_active, channel_valid);
    end
    for (int k = 1; k < H; k++) begin
      if (k == 3) err[2] = 8'd0;
      step();
      n_tests++;
      if ({holdoff_active, active_channel, switch_pulse} !== {1'b1, 2'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL holdoff_cycle%0d got h=%b act=%0d p=%b want 1/3/0", k, holdoff_active,
                 active_channel, switch_pulse);
      end
    end
    step();
    n_tests++;
    if ({holdoff_active, active_channel, switch_pulse} !== {1'b0, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL holdoff_end got h=%b act=%0d p=%b want 0/3/0", holdoff_active,
               active_channel, switch_pulse);
    end
    step();
    n_tests++;
    if ({active_channel, switch_pulse, holdoff_active} !== {2'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL revert got act=%0d p=%b h=%b want 2/1/1", active_channel, switch_pulse,
               holdoff_active);
    end
  endtask

  task automatic test_no_signal();
    setup_config();
    signal_present = 4'b0000;
    step();
    n_tests++;
    if ({no_signal, active_channel, channel_valid, switch_pulse} !== {1'b1, 2'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL nosig_enter got n=%b act=%0d v=%b p=%b want 1/2/0/0", no_signal,
               active_channel, channel_valid, switch_pulse);
    end
    step();
    n_tests++;
    if ({no_signal, active_channel} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL nosig_hold got n=%b act=%0d want 1/2", no_signal, active_channel);
    end
    signal_present = 4'b0010;
    step();
    n_tests++;
    if ({active_channel, switch_pulse, holdoff_active, no_signal} !== {2'd1, 3'b110}) begin
      n_fail++;
      $display("FAIL nosig_recover got act=%0d p=%b h=%b n=%b want 1/1/1/0", active_channel,
               switch_pulse, holdoff_active, no_signal);
    end
    signal_present = 4'hF;
  endtask

  task automatic test_manual();
    setup_config();
    err[2] = 8'd16;
    step();
    step();
    manual_enable = 1; manual_channel = 2'd1;
    step();
    n_tests++;
    if ({active_channel, holdoff_active, switch_pulse} !== {2'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL manual_override got act=%0d h=%b p=%b want 1/0/1", active_channel,
               holdoff_active, switch_pulse);
    end
    manual_channel = 2'd0;
    step();
    n_tests++;
    if ({active_channel, switch_pulse} !== {2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL manual_follow got act=%0d p=%b want 0/1", active_channel, switch_pulse);
    end
    step();
    n_tests++;
    if (switch_pulse !== 1'b0) begin
      n_fail++; $display("FAIL manual_no_pulse got p=%b want 0", switch_pulse);
    end
    err[2] = 8'd0; fallback_enable = 0; signal_present = 4'b1110; manual_enable = 0;
    step();
    n_tests++;
    if ({active_channel, switch_pulse, holdoff_active, no_signal, channel_valid}
        !== {2'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL manual_exit got act=%0d p=%b h=%b n=%b v=%b want 0/0/0/0/0",
               active_channel, switch_pulse, holdoff_active, no_signal, channel_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({active_channel, switch_pulse} !== {2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL no_fallback%0d got act=%0d p=%b want 0/0", k, active_channel,
                 switch_pulse);
      end
    end
    fallback_enable = 1; signal_present = 4'hF;
  endtask

  task automatic test_error_window();
    int last;
    int cnt;
    int bad;
    setup_config();
    reset_timer = 20'd5;
    last = -1; cnt = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (error_clear !== 4'h0 && error_clear !== 4'hF) bad++;
      if (error_clear === 4'hF) begin
        if (last >= 0) begin
          n_tests++;
          if (i - last != 5) begin
            n_fail++; $display("FAIL clear_spacing got %0d want 5", i - last);
          end
        end
        last = i;
        cnt++;
      end
    end
    n_tests++;
    if (cnt != 10 || bad != 0) begin
      n_fail++; $display("FAIL clear_count got %0d (bad %0d) want 10 (bad 0)", cnt, bad);
    end
    reset_timer = 20'd0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (error_clear !== 4'h0) cnt++;
    end
    n_tests++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL clear_disabled got %0d strobes want 0", cnt);
    end
    reset_timer = 20'd100;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (error_clear !== 4'h0) cnt++;
    end
    reset_timer = 20'd10;
    step();
    n_tests++;
    if (cnt != 0 || error_clear !== 4'hF) begin
      n_fail++;
      $display("FAIL clear_lowered got early=%0d clr=%h want 0/f", cnt, error_clear);
    end
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (error_clear !== 4'h0) cnt++;
    end
    step();
    n_tests++;
    if (cnt != 0 || error_clear !== 4'hF) begin
      n_fail++;
      $display("FAIL clear_after_lower got early=%0d clr=%h want 0/f", cnt, error_clear);
    end
    reset_timer = 20'd0;
  endtask

  task automatic test_reset_holdoff();
    setup_config();
    reset_timer = 20'd3;
    err[2] = 8'd16;
    step();
    step();
    step();
    n_tests++;
    if (holdoff_active !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_holdoff got h=%b want 1", holdoff_active);
    end
    rst = 1;
    step();
    n_tests++;
    if ({active_channel, channel_valid, switch_pulse, holdoff_active, no_signal, error_clear}
        !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_holdoff got act=%0d v%b p%b h%b n%b c%h want all 0",
               active_channel, channel_valid, switch_pulse, holdoff_active, no_signal,
               error_clear);
    end
    rst = 0; err[2] = 8'd0; reset_timer = 20'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against the model
  // ---------------------------------------------------------------------------
  task automatic test_random();
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      valid_config = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 39) == 0) manual_enable = ~manual_enable;
      if ($urandom_range(0, 3) == 0) manual_channel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) fallback_enable = ~fallback_enable;
      if ($urandom_range(0, 9) == 0) signal_present[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) signal_present = 4'h0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 14) == 0) err[i] = 8'($urandom_range(10, 20));
      if ($urandom_range(0, 199) == 0) channel_priority = 8'($urandom);
      if ($urandom_range(0, 299) == 0) reset_timer = 20'($urandom_range(0, 12));
      step();
      n_tests++;
      if (active_channel !== e_act) begin
        n_fail++; $display("FAIL rnd_active cyc%0d got %0d want %0d", n, active_channel, e_act);
      end
      n_tests++;
      if ({channel_valid, switch_pulse, holdoff_active, no_signal}
          !== {e_valid, e_pulse, e_hold, e_nosig}) begin
        n_fail++;
        $display("FAIL rnd_flags cyc%0d got v%b p%b h%b n%b want v%b p%b h%b n%b", n,
                 channel_valid, switch_pulse, holdoff_active, no_signal, e_valid, e_pulse,
                 e_hold, e_nosig);
      end
      n_tests++;
      if (error_clear !== e_clr) begin
        n_fail++; $display("FAIL rnd_clear cyc%0d got %h want %h", n, error_clear, e_clr);
      end
    end
  endtask

  initial begin
    rst = 1; fallback_enable = 1; manual_enable = 0; manual_channel = 2'd0;
    channel_priority = 8'b00_01_11_10; reset_timer = 20'd0; valid_config = 0;
    signal_present = 4'hF;
    for (int i = 0; i < 4; i++) err[i] = 8'd0;
    test_reset();
    test_config();
    test_failover();
    test_no_signal();
    test_manual();
    test_error_window();
    test_reset_holdoff();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qos_channel_selector.md
QOS_CHANNEL_SELECTOR -- requirements
Module: qos_channel_selector

Interface
REQ-001 SHALL have parameter ERR_THRESH, default 8'd16, error count at or above which a channel is unhealthy.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 1024, post-switch lockout length in clk cycles (>=1).
REQ-003 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-004 SHALL have ports: fallback_enable in 1, manual_enable in 1, manual_channel in 2, channel_priority in 8, reset_timer in 20, valid_config in 1 (config from register block).
REQ-005 SHALL have ports: signal_present in 4, error_count_ch0..ch3 in 8 each (per-channel status).
REQ-006 SHALL have outputs: active_channel out 2 selected TS channel; channel_valid out 1 selected channel healthy; switch_pulse out 1 one-cycle strobe on every active_channel change; holdoff_active out 1 lockout in progress; error_clear out 4 per-channel error-counter clear strobe; no_signal out 1 no healthy channel exists.

Function
REQ-007 SHALL define healthy[i] = signal_present[i] AND error_count_chi < ERR_THRESH, combinationally.
REQ-008 SHALL decode channel_priority as rank list: [1:0] highest, [3:2], [5:4], [7:6] lowest; duplicate entries take the first (highest) rank; unlisted channels are never auto-selected.
REQ-009 SHALL define best = highest-ranked healthy listed channel; best_valid = such a channel exists.
REQ-010 SHALL implement FSM states WAIT_CFG, MANUAL, AUTO_RUN, HOLDOFF, NO_SIG; all outputs registered, 1-cycle latency from inputs.
REQ-011 WAIT_CFG: active_channel=0, channel_valid=0; on valid_config=1 go MANUAL if manual_enable, else AUTO_RUN with active_channel=best if best_valid, else NO_SIG with active_channel=channel_priority[1:0].
REQ-012 From any state except WAIT_CFG, manual_enable=1 SHALL go MANUAL next cycle, overriding HOLDOFF.
REQ-013 MANUAL: active_channel follows manual_channel each cycle; manual_enable=0 -> AUTO_RUN, active_channel unchanged.
REQ-014 AUTO_RUN with fallback_enable=1: if best_valid and best differs from active_channel (current unhealthy, or higher-ranked channel healthy), load best, pulse switch_pulse, go HOLDOFF.
REQ-015 AUTO_RUN: if no channel healthy, hold active_channel and go NO_SIG regardless of fallback_enable.
REQ-016 AUTO_RUN with fallback_enable=0: never change active_channel.
REQ-017 HOLDOFF: count HOLDOFF_CYCLES cycles, no auto switch, holdoff_active=1; at terminal count -> AUTO_RUN and re-evaluate next cycle.
REQ-018 NO_SIG: no_signal=1; when best_valid and fallback_enable=1, switch to best (pulse only if changed) and go HOLDOFF; when fallback_enable=0, return to AUTO_RUN only when current channel becomes healthy.
REQ-019 switch_pulse SHALL assert for exactly one cycle on every active_channel change, including MANUAL changes; never when value unchanged.
REQ-020 channel_valid SHALL equal registered healthy[active_channel].
REQ-021 Error window: 20-bit counter increments each cycle; when counter >= reset_timer-1 and reset_timer != 0, error_clear=4'b1111 for one cycle and counter returns to 0.
REQ-022 reset_timer=0 SHALL disable error_clear and hold counter at 0; lowering reset_timer below current count SHALL fire on next cycle (>= compare).
REQ-023 valid_config falling to 0 SHALL return to WAIT_CFG next cycle.

Reset
REQ-024 rst=1 at a clk edge SHALL set state WAIT_CFG, active_channel=0, all strobes 0, channel_valid=0, no_signal=0, holdoff_active=0, both counters 0, including mid-HOLDOFF.

Verification
REQ-025 Config: priority=8'b00_01_11_10, fallback=1, all healthy, valid_config 0->1 -> active_channel=2 one cycle later, state AUTO_RUN.
REQ-026 Failover: ch2 error_count=16 -> active_channel=3, switch_pulse one cycle, holdoff_active=1 for HOLDOFF_CYCLES; ch2 recovers mid-holdoff -> no switch until holdoff ends, then revert to 2 with pulse.
REQ-027 All signal_present=0 -> no_signal=1, active_channel held; ch1 present -> switch to 1 and HOLDOFF.
REQ-028 manual_enable=1, manual_channel=1 during HOLDOFF -> active_channel=1 next cycle, holdoff_active=0; fallback=0 with current unhealthy -> no switch.
REQ-029 reset_timer=5 -> error_clear=4'hF every 5 cycles; reset_timer=0 -> never; rst mid-HOLDOFF -> all outputs to reset values next cycle.
